knowles_prefix_pipe: RTL



---
 rtl/knowles_prefix_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/knowles_prefix_pipe.sv
// Three-stage Knowles [1,1,...,1] prefix carry network with a bubble-collapsing
// valid/ready pipeline: S1 folds carry-in, S2 runs the lower prefix levels, S3 the rest plus sum.
module knowles_prefix_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int L  = $clog2(WIDTH);
  localparam int LH = (L + 1) / 2;

  // One prefix level of span s; result packed as {P', G'}.
  function automatic logic [2*WIDTH-1:0] prefix_level(input logic [WIDTH-1:0] g,
                                                      input logic [WIDTH-1:0] p,
                                                      input int s);
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    gn = g;
    pn = p;
    for (int i = s; i < WIDTH; i++) begin
      gn[i] = g[i] | (p[i] & g[i-s]);
      pn[i] = p[i] & p[i-s];
    end
    return {pn, gn};
  endfunction

  logic             v1_q, v2_q, v3_q;
  logic             ready1, ready2, ready3;
  logic [WIDTH-1:0] g1_d, g1_q, p1_q, r1_q;
  logic             c1_q;
  logic [WIDTH-1:0] g2_d, p2_d, g2_q, p2_q, r2_q;
  logic             c2_q;
  logic [2*WIDTH-1:0] gp2, gp3;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q;

  assign ready3   = !v3_q || out_ready;
  assign ready2   = !v2_q || ready3;
  assign ready1   = !v1_q || ready2;
  assign in_ready = ready1;

  assign g1_d = {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & c_in)};

  always_comb begin
    gp2 = {p1_q, g1_q};
    for (int k = 1; k <= LH; k++) begin
      gp2 = prefix_level(gp2[WIDTH-1:0], gp2[2*WIDTH-1:WIDTH], 1 << (k - 1));
    end
    g2_d = gp2[WIDTH-1:0];
    p2_d = gp2[2*WIDTH-1:WIDTH];
  end

  // Only the group-generate survives to the carries; the final P is dropped.
  always_comb begin
    gp3 = {p2_q, g2_q};
    for (int k = LH + 1; k <= L; k++) begin
      gp3 = prefix_level(gp3[WIDTH-1:0], gp3[2*WIDTH-1:WIDTH], 1 << (k - 1));
    end
    carry  = gp3[WIDTH-1:0];
    sum_d  = r2_q ^ {carry[WIDTH-2:0], c2_q};
    cout_d = carry[WIDTH-1];
    ovf_d  = carry[WIDTH-2] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      r1_q   <= '0;
      c1_q   <= 1'b0;
      g2_q   <= '0;
      p2_q   <= '0;
      r2_q   <= '0;
      c2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (ready1) v1_q <= in_valid;
      if (ready1 && in_valid) begin
        g1_q <= g1_d;
        p1_q <= p_in;
        r1_q <= p_in;
        c1_q <= c_in;
      end
      if (ready2) v2_q <= v1_q;
      if (ready2 && v1_q) begin
        g2_q <= g2_d;
        p2_q <= p2_d;
        r2_q <= r1_q;
        c2_q <= c1_q;
      end
      if (ready3) v3_q <= v2_q;
      if (ready3 && v2_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = v3_q;

endmodule
